// File: rtl/np_led_pwm.sv
`default_nettype none
// ============================================================================
// Module   : np_led_pwm
// Brief    : iomem-mapped 8-channel LED PWM, double-buffered duty, wrap irq
// Revision : 1.0 - initial release
// ============================================================================
module np_led_pwm #(
    parameter logic [7:0] BASE_ADDR = 8'h04
) (
    input  logic        core_clock,
    input  logic        reset_core,
    input  logic        iomem_valid,
    output logic        iomem_ready,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    output logic [7:0]  led,
    output logic        irq
);
    localparam logic [1:0] c_OFF_CTRL    = 2'd0;
    localparam logic [1:0] c_OFF_DUTY_LO = 2'd1;
    localparam logic [1:0] c_OFF_DUTY_HI = 2'd2;
    localparam logic [1:0] c_OFF_STATUS  = 2'd3;

    logic        r_ready;
    logic [31:0] r_rdata;
    logic        r_enable;
    logic        r_irq_en;
    logic [7:0]  r_prescale;
    logic [63:0] r_pend;
    logic [63:0] r_act;
    logic [7:0]  r_pre_cnt;
    logic [7:0]  r_pwm_cnt;
    logic        r_flag;
    logic [7:0]  r_led;
    logic        r_irq;

    logic        w_sel;
    logic        w_wr;
    logic [1:0]  w_off;
    logic        w_en_next;
    logic        w_tick;
    logic        w_wrap;
    logic        w_flag_clr;
    logic [31:0] w_rdata;
    logic        w_unused;

    assign w_sel      = iomem_valid && !r_ready && (iomem_addr[31:24] == BASE_ADDR);
    assign w_off      = iomem_addr[3:2];
    assign w_wr       = w_sel && (iomem_wstrb != 4'b0000);
    // Counters clear on the enable value being written, so a disable write
    // zeroes them on the very next cycle; counting itself uses the live enable.
    assign w_en_next  = (w_wr && (w_off == c_OFF_CTRL) && iomem_wstrb[0]) ? iomem_wdata[0] : r_enable;
    assign w_tick     = r_enable && (r_pre_cnt >= r_prescale);
    assign w_wrap     = w_tick && w_en_next && (r_pwm_cnt == 8'hFF);
    assign w_flag_clr = w_wr && (w_off == c_OFF_STATUS) && iomem_wstrb[1] && iomem_wdata[8];
    assign w_unused   = ^{iomem_addr[23:4], iomem_addr[1:0]};

    always_comb begin
        w_rdata = 32'h0000_0000;
        case (w_off)
            c_OFF_CTRL:    w_rdata = {16'h0000, r_prescale, 6'b000000, r_irq_en, r_enable};
            c_OFF_DUTY_LO: w_rdata = r_pend[31:0];
            c_OFF_DUTY_HI: w_rdata = r_pend[63:32];
            default:       w_rdata = {23'h000000, r_flag, r_pwm_cnt};
        endcase
    end

    always_ff @(posedge core_clock) begin
        if (reset_core) begin
            r_ready    <= 1'b0;
            r_rdata    <= 32'h0000_0000;
            r_enable   <= 1'b0;
            r_irq_en   <= 1'b0;
            r_prescale <= 8'h00;
            r_pend     <= 64'h0;
        end else begin
            r_ready <= w_sel;
            if (w_sel) begin
                r_rdata <= w_rdata;
            end
            if (w_wr) begin
                case (w_off)
                    c_OFF_CTRL: begin
                        if (iomem_wstrb[0]) begin
                            r_enable <= iomem_wdata[0];
                            r_irq_en <= iomem_wdata[1];
                        end
                        if (iomem_wstrb[1]) begin
                            r_prescale <= iomem_wdata[15:8];
                        end
                    end
                    c_OFF_DUTY_LO: begin
                        for (int b = 0; b < 4; b++) begin
                            if (iomem_wstrb[b]) r_pend[8*b +: 8] <= iomem_wdata[8*b +: 8];
                        end
                    end
                    c_OFF_DUTY_HI: begin
                        for (int b = 0; b < 4; b++) begin
                            if (iomem_wstrb[b]) r_pend[32 + 8*b +: 8] <= iomem_wdata[8*b +: 8];
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge core_clock) begin
        if (reset_core) begin
            r_pre_cnt <= 8'h00;
            r_pwm_cnt <= 8'h00;
            r_act     <= 64'h0;
            r_flag    <= 1'b0;
            r_led     <= 8'h00;
            r_irq     <= 1'b0;
        end else begin
            if (!w_en_next) begin
                r_pre_cnt <= 8'h00;
                r_pwm_cnt <= 8'h00;
            end else if (w_tick) begin
                r_pre_cnt <= 8'h00;
                r_pwm_cnt <= r_pwm_cnt + 8'd1;
            end else if (r_enable) begin
                r_pre_cnt <= r_pre_cnt + 8'd1;
            end
            // Active duty tracks pending while idle and latches only on a wrap
            // while running; a same-cycle pending write lands one period later.
            if (!r_enable || w_wrap) begin
                r_act <= r_pend;
            end
            if (w_wrap) begin
                r_flag <= 1'b1;
            end else if (w_flag_clr) begin
                r_flag <= 1'b0;
            end
            for (int i = 0; i < 8; i++) begin
                r_led[i] <= r_enable && (r_pwm_cnt < r_act[8*i +: 8]);
            end
            r_irq <= w_wrap && r_irq_en;
        end
    end

    assign iomem_ready = r_ready;
    assign iomem_rdata = r_rdata;
    assign led         = r_led;
    assign irq         = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_np_led_pwm.sv
`timescale 1ns/1ps
`default_nettype none
// tb_np_led_pwm: directed plus randomized checks of np_led_pwm against an
// arithmetic model (pwm_cnt = cycles_enabled / (prescale+1) mod 256).
module tb_np_led_pwm;
    localparam logic [7:0] BASE = 8'h04;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic [31:0] rdata;
    logic [7:0]  led;
    logic        irq;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int xfer_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    np_led_pwm #(.BASE_ADDR(BASE)) dut (
        .core_clock  (clk),
        .reset_core  (rst),
        .iomem_valid (valid),
        .iomem_ready (ready),
        .iomem_wstrb (wstrb),
        .iomem_addr  (addr),
        .iomem_wdata (wdata),
        .iomem_rdata (rdata),
        .led         (led),
        .irq         (irq)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: observed 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step();
    endtask

    // One access; xfer_cyc records the cycle in which the request is selected.
    task automatic bus(input logic [1:0] off, input logic [31:0] wd, input logic [3:0] st,
                       output logic [31:0] rd);
        int n = 0;
        if (ready) step();
        valid    = 1'b1;
        addr     = {BASE, 20'($urandom), off, 2'($urandom)};
        wdata    = wd;
        wstrb    = st;
        xfer_cyc = cyc;
        do begin
            step();
            n++;
        end while (!ready && n < 8);
        check("bus_ready", {31'b0, ready}, 32'd1);
        rd    = rdata;
        valid = 1'b0;
        wstrb = 4'b0000;
    endtask

    task automatic wr(input logic [1:0] off, input logic [31:0] d, input logic [3:0] st);
        logic [31:0] dummy;
        bus(off, d, st, dummy);
    endtask

    task automatic rd(input logic [1:0] off, output logic [31:0] d);
        bus(off, 32'($urandom), 4'b0000, d);
    endtask

    function automatic int pwm_at(input int k, input int p);
        return (k / (p + 1)) % 256;
    endfunction

    function automatic logic [7:0] pick_duty();
        int r = $urandom_range(0, 5);
        if (r == 0) return 8'h00;
        if (r == 1) return 8'hFF;
        return 8'($urandom);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        logic [63:0] old_v;
        logic [63:0] new_v;
        logic [63:0] act_v;
        logic [7:0]  e;
        int t0, k, p, per, w, hi, edges, bank;
        int cnt[8];
        int exp_cnt[8];
        logic prev;

        rst = 1'b1; valid = 1'b0; wstrb = 4'b0000; addr = 32'h0; wdata = 32'h0;
        repeat (3) step();
        rst = 1'b0;
        step();

        // Reset state and single-cycle ready
        check("reset_led", {24'h0, led}, 32'h0);
        check("reset_irq", {31'b0, irq}, 32'h0);
        check("reset_ready", {31'b0, ready}, 32'h0);
        for (int o = 0; o < 4; o++) begin
            rd(2'(o), d);
            check($sformatf("reset_reg%0d", o), d, 32'h0);
            step();
            check("ready_one_cycle", {31'b0, ready}, 32'h0);
        end

        // Another block's window must never be acknowledged
        valid = 1'b1; addr = 32'h0500_0000; wdata = 32'hFFFF_FFFF; wstrb = 4'hF;
        repeat (4) begin
            step();
            check("foreign_ready", {31'b0, ready}, 32'h0);
        end
        valid = 1'b0; wstrb = 4'h0;
        rd(2'd0, d);
        check("foreign_no_write", d, 32'h0);

        // Byte strobes and CTRL read mask
        wr(2'd2, 32'hAABB_CCDD, 4'b0100);
        rd(2'd2, d);
        check("strobe_duty_hi", d, 32'h00BB_0000);
        wr(2'd0, 32'hFFFF_FFFE, 4'hF);
        rd(2'd0, d);
        check("ctrl_mask", d, 32'h0000_FF02);
        wr(2'd0, 32'h0, 4'hF);
        wr(2'd2, 32'h0, 4'hF);

        // Basic PWM, prescale 0: high count over one period equals duty
        wr(2'd1, 32'h00FF_8000, 4'hF);
        wr(2'd2, 32'h0000_0001, 4'hF);
        wr(2'd0, 32'h0000_0001, 4'hF);
        t0 = xfer_cyc;
        exp_cnt = '{0, 128, 255, 0, 1, 0, 0, 0};
        for (int i = 0; i < 8; i++) cnt[i] = 0;
        do begin
            @(negedge clk);
            k = cyc - t0 - 1;
            if (k >= 257) for (int i = 0; i < 8; i++) cnt[i] += int'(led[i]);
        end while (k < 512);
        for (int i = 0; i < 8; i++) check($sformatf("basic_ch%0d_high", i), cnt[i], exp_cnt[i]);
        step();
        wr(2'd0, 32'h0, 4'hF);
        @(negedge clk);
        @(negedge clk);
        check("disable_led_off", {24'h0, led}, 32'h0);
        step();
        rd(2'd3, d);
        check("disable_status", d, 32'h0000_0100);
        wr(2'd3, 32'h0000_0100, 4'b0010);
        rd(2'd3, d);
        check("w1c_clear_idle", d, 32'h0);

        // Prescale 3: STATUS advances every 4 cycles, ch0 duty 0x40 -> 256 contiguous
        wr(2'd1, 32'h0000_0040, 4'hF);
        wr(2'd0, 32'h0000_0301, 4'hF);
        t0 = xfer_cyc;
        for (int j = 0; j < 3; j++) begin
            repeat ($urandom_range(1, 6)) step();
            rd(2'd3, d);
            k = xfer_cyc - t0 - 1;
            check("pre_status", d, 32'(pwm_at(k, 3)));
        end
        hi = 0; edges = 0; prev = 1'b0;
        do begin
            @(negedge clk);
            k = cyc - t0 - 1;
            if (k == 1024) prev = led[0];
            if (k > 1024) begin
                hi += int'(led[0]);
                if (led[0] && !prev) edges++;
                prev = led[0];
            end
        end while (k < 2048);
        check("pre_ch0_high", hi, 256);
        check("pre_ch0_contig", edges, 1);
        step();
        rd(2'd3, d);
        k = xfer_cyc - t0 - 1;
        check("pre_status_flag", d, 32'h100 | 32'(pwm_at(k, 3)));
        wr(2'd0, 32'h0, 4'hF);

        // IRQ and flag, including W1C on the wrap cycle
        wr(2'd3, 32'h0000_0100, 4'b0010);
        wr(2'd0, 32'h0000_0003, 4'hF);
        t0 = xfer_cyc;
        wait_until(t0 + 1 + 300);
        rd(2'd3, d);
        check("irq_flag_set", {31'b0, d[8]}, 32'h1);
        wr(2'd3, 32'h0000_0100, 4'b0010);
        rd(2'd3, d);
        check("irq_flag_w1c", {31'b0, d[8]}, 32'h0);
        wait_until(t0 + 512);
        wr(2'd3, 32'h0000_0100, 4'b0010);
        check("irq_pulse", {31'b0, irq}, 32'h1);
        step();
        check("irq_one_cycle", {31'b0, irq}, 32'h0);
        rd(2'd3, d);
        check("w1c_vs_wrap", {31'b0, d[8]}, 32'h1);
        wr(2'd0, 32'h0, 4'hF);

        // Randomized trials with a mid-run duty update (trial 0 lands on the wrap cycle)
        for (int trial = 0; trial < 4; trial++) begin
            p   = $urandom_range(0, 2);
            per = 256 * (p + 1);
            for (int i = 0; i < 8; i++) old_v[8*i +: 8] = pick_duty();
            new_v = old_v;
            bank  = $urandom_range(0, 1);
            for (int i = 0; i < 4; i++) new_v[32*bank + 8*i +: 8] = pick_duty();
            wr(2'd1, old_v[31:0], 4'hF);
            wr(2'd2, old_v[63:32], 4'hF);
            wr(2'd0, 32'(p << 8) | 32'h3, 4'hF);
            t0 = xfer_cyc;
            w  = (trial == 0) ? t0 + per : t0 + 2 + $urandom_range(0, per + per / 2);
            xfer_cyc = 32'h7FFF_FFFF;
            fork
                begin : monitor
                    int km;
                    act_v = old_v;
                    do begin
                        @(negedge clk);
                        km = cyc - t0 - 1;
                        e  = 8'h00;
                        for (int i = 0; i < 8; i++)
                            if (km > 0 && pwm_at(km - 1, p) < int'(act_v[8*i +: 8])) e[i] = 1'b1;
                        check("rand_led", {24'h0, led}, {24'h0, e});
                        check("rand_irq", {31'b0, irq}, (km > 0 && km % per == 0) ? 32'h1 : 32'h0);
                        if (km > 0 && km % per == 0) act_v = (cyc - 1 > xfer_cyc) ? new_v : old_v;
                    end while (km < 2 * per + 8);
                end
                begin : writer
                    wait_until(w);
                    wr(2'(bank + 1), bank ? new_v[63:32] : new_v[31:0], 4'hF);
                end
            join
            step();
            rd(2'd3, d);
            k = xfer_cyc - t0 - 1;
            check("rand_status", d, 32'h100 | 32'(pwm_at(k, p)));
            rd(2'(bank + 1), d);
            check("rand_pending_read", d, bank ? new_v[63:32] : new_v[31:0]);
            wr(2'd0, 32'h0, 4'hF);
        end

        // Reset while a request is pending
        wr(2'd1, 32'h1234_5678, 4'hF);
        wr(2'd0, 32'h0000_0103, 4'hF);
        repeat (10) step();
        valid = 1'b1; addr = {BASE, 24'h0}; wdata = 32'hFFFF_FFFF; wstrb = 4'hF;
        rst = 1'b1;
        step();
        check("rst_no_ready", {31'b0, ready}, 32'h0);
        valid = 1'b0; wstrb = 4'h0; rst = 1'b0;
        step();
        check("rst_no_ready2", {31'b0, ready}, 32'h0);
        check("rst_led", {24'h0, led}, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);
        for (int o = 0; o < 4; o++) begin
            rd(2'(o), d);
            check($sformatf("rst_reg%0d", o), d, 32'h0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
